// File: rtl/wb_cpu_sequencer.sv
// wb_cpu_sequencer
//   Multi-cycle sequencer between a single-cycle RISC-V core and one Wishbone
//   classic bus. It runs each instruction as FETCH -> EXEC -> (DATA) -> COMMIT:
//   it fetches at core_pc, gives the core datapath one cycle to settle, runs at
//   most one load/store cycle, then pulses core_en for one cycle. A bus error
//   or a strobe timeout parks it in FAULT until reset.
// Ports
//   clk, reset                      clock, async active-low reset
//   core_pc/addr/wdata/memwrite/memread   core-side request inputs
//   core_instr, core_rdata, core_en       latched instruction/load data, commit strobe
//   wb_*                            Wishbone classic master
//   fault, fault_addr               sticky fault flag and word address of the faulting access
//   instret                         retired-instruction counter (wraps)
module wb_cpu_sequencer #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] core_pc,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic        core_memwrite,
  input  logic        core_memread,
  output logic [31:0] core_instr,
  output logic [31:0] core_rdata,
  output logic        core_en,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        fault,
  output logic [31:0] fault_addr,
  output logic [31:0] instret
);

  localparam int TW = $clog2(TIMEOUT + 2);
  localparam logic [TW-1:0] TMO_LAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH, S_EXEC, S_DATA, S_COMMIT, S_FAULT
  } state_t;

  state_t        state_q;
  logic [31:0]   instr_q, rdata_q, adr_q, dat_q, faddr_q, instret_q;
  logic          stb_q, we_q, en_q, fault_q;
  logic [TW-1:0] tmo_q;
  logic          tmo_hit;

  // Strobe has been high for TIMEOUT cycles including the current one.
  assign tmo_hit = (TIMEOUT != 0) && stb_q && (tmo_q == TMO_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      instr_q   <= 32'h0000_0013;
      rdata_q   <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
      faddr_q   <= '0;
      instret_q <= '0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      en_q      <= 1'b0;
      fault_q   <= 1'b0;
      tmo_q     <= '0;
    end else begin
      en_q <= 1'b0;
      case (state_q)
        S_FETCH: begin
          if (!stb_q) begin
            // Fetch pending after reset: raise the strobe on this edge.
            stb_q <= 1'b1;
            we_q  <= 1'b0;
            adr_q <= {core_pc[31:2], 2'b00};
            tmo_q <= '0;
          end else if (wb_err_i || (tmo_hit && !wb_ack_i)) begin
            stb_q   <= 1'b0;
            fault_q <= 1'b1;
            faddr_q <= adr_q;
            state_q <= S_FAULT;
          end else if (wb_ack_i) begin
            instr_q <= wb_dat_i;
            stb_q   <= 1'b0;
            state_q <= S_EXEC;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_EXEC: begin
          // Datapath has settled; store takes priority over load.
          if (core_memwrite || core_memread) begin
            stb_q   <= 1'b1;
            we_q    <= core_memwrite;
            adr_q   <= {core_addr[31:2], 2'b00};
            dat_q   <= core_wdata;
            tmo_q   <= '0;
            state_q <= S_DATA;
          end else begin
            en_q    <= 1'b1;
            state_q <= S_COMMIT;
          end
        end
        S_DATA: begin
          if (wb_err_i || (tmo_hit && !wb_ack_i)) begin
            stb_q   <= 1'b0;
            fault_q <= 1'b1;
            faddr_q <= adr_q;
            state_q <= S_FAULT;
          end else if (wb_ack_i) begin
            if (!we_q) rdata_q <= wb_dat_i;
            stb_q   <= 1'b0;
            en_q    <= 1'b1;
            state_q <= S_COMMIT;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_COMMIT: begin
          // Core's PC commits on this edge; the next fetch starts immediately.
          instret_q <= instret_q + 32'd1;
          stb_q     <= 1'b1;
          we_q      <= 1'b0;
          adr_q     <= {core_pc[31:2], 2'b00};
          tmo_q     <= '0;
          state_q   <= S_FETCH;
        end
        default: begin
          // FAULT: absorbing until reset.
          stb_q <= 1'b0;
        end
      endcase
    end
  end

  assign core_instr = instr_q;
  assign core_rdata = rdata_q;
  assign core_en    = en_q;
  assign wb_cyc_o   = stb_q;
  assign wb_stb_o   = stb_q;
  assign wb_we_o    = we_q;
  assign wb_adr_o   = adr_q;
  assign wb_dat_o   = dat_q;
  assign wb_sel_o   = {4{stb_q}};
  assign fault      = fault_q;
  assign fault_addr = faddr_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_wb_cpu_sequencer.sv
module tb_wb_cpu_sequencer;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] core_pc, core_addr, core_wdata;
  logic        core_memwrite, core_memread;
  logic [31:0] core_instr, core_rdata;
  logic        core_en;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i, wb_err_i;
  logic        fault;
  logic [31:0] fault_addr, instret;

  wb_cpu_sequencer #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .core_pc(core_pc), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_memwrite(core_memwrite), .core_memread(core_memread),
    .core_instr(core_instr), .core_rdata(core_rdata), .core_en(core_en),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .fault(fault), .fault_addr(fault_addr), .instret(instret)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: expected bus cycles (in issue order) and expected commits.
  typedef struct { logic we; logic [31:0] adr; logic [31:0] dat; } bus_t;
  typedef struct { logic [31:0] instr; logic [31:0] rdata; logic [31:0] cnt; } cmt_t;
  bus_t exp_bus[$];
  cmt_t exp_cmt[$];
  bit   mon_en = 1'b0;
  logic stb_prev = 1'b0;
  logic [31:0] rdata_m = '0;
  int          ncommit = 0;

  // Monitor: compares each new bus cycle and each commit against the queues.
  always @(negedge clk) begin
    bus_t e;
    cmt_t c;
    if (mon_en) begin
      if (wb_stb_o && !stb_prev) begin
        if (exp_bus.size() == 0) chk("bus_unexpected", 32'd1, 32'd0);
        else begin
          e = exp_bus.pop_front();
          chk("bus_we", 32'(wb_we_o), 32'(e.we));
          chk("bus_adr", wb_adr_o, e.adr);
          chk("bus_cyc", 32'(wb_cyc_o), 32'd1);
          chk("bus_sel", 32'(wb_sel_o), 32'hF);
          if (e.we) chk("bus_dat", wb_dat_o, e.dat);
        end
      end
      if (core_en) begin
        if (exp_cmt.size() == 0) chk("commit_unexpected", 32'd1, 32'd0);
        else begin
          c = exp_cmt.pop_front();
          chk("commit_instr", core_instr, c.instr);
          chk("commit_rdata", core_rdata, c.rdata);
          chk("commit_instret", instret, c.cnt);
          chk("commit_sel_idle", 32'(wb_sel_o), 32'h0);
        end
      end
    end
    stb_prev = wb_stb_o;
  end

  task automatic wait_stb(output int n);
    n = 0;
    while (!wb_stb_o && n < 20) begin @(negedge clk); n++; end
  endtask

  task automatic wait_en(output int n);
    n = 0;
    while (!core_en && n < 20) begin @(negedge clk); n++; end
  endtask

  // Slave: hold off for 'waits' cycles, then terminate for one cycle.
  task automatic respond(input int waits, input logic [31:0] data, input logic ack, input logic err);
    repeat (waits) @(negedge clk);
    wb_dat_i = data; wb_ack_i = ack; wb_err_i = err;
    @(negedge clk);
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = $urandom;
  endtask

  // ty: 0 ALU, 1 load, 2 store, 3 store+load flags (store wins).
  task automatic run_instr(input logic [1:0] ty, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] word, input logic [31:0] ld, input int fw,
                           input int dw, input int gap);
    int n;
    bit mem;
    wait_stb(n);
    if (gap >= 0) chk("fetch_gap", 32'(n), 32'(gap));
    mem = (ty != 2'd0);
    core_memwrite = ty[1]; core_memread = ty[0]; core_addr = addr; core_wdata = wd;
    if (mem) exp_bus.push_back('{ty[1], {addr[31:2], 2'b00}, wd});
    if (ty == 2'd1) rdata_m = ld;
    exp_cmt.push_back('{word, rdata_m, 32'(ncommit)});
    ncommit++;
    respond(fw, word, 1'b1, 1'b0);
    if (mem) begin
      wait_stb(n);
      chk("data_gap", 32'(n), 32'd1);
      respond(dw, ld, 1'b1, 1'b0);
    end
    wait_en(n);
    chk("commit_latency", 32'(n), mem ? 32'd0 : 32'd1);
    // Core presents its next PC while committing.
    core_pc = $urandom;
    exp_bus.push_back('{1'b0, {core_pc[31:2], 2'b00}, 32'h0});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt;
    bit bad;
    logic [31:0] w, ir;
    reset = 1'b1;
    core_pc = '0; core_addr = '0; core_wdata = '0;
    core_memwrite = 1'b0; core_memread = 1'b0;
    wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_instr", core_instr, 32'h0000_0013);
    chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("rst_stb", 32'(wb_stb_o), 32'd0);
    chk("rst_sel", 32'(wb_sel_o), 32'd0);
    chk("rst_en", 32'(core_en), 32'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_rdata", core_rdata, 32'd0);

    exp_bus.push_back('{1'b0, 32'h0, 32'h0});
    mon_en = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    chk("first_fetch_stb", 32'(wb_stb_o), 32'd1);

    // Directed: ADDI with zero-wait fetch, misaligned load, store with both flags.
    run_instr(2'd0, 32'h0, 32'h0, 32'h0010_0093, 32'h0, 0, 0, 0);
    run_instr(2'd1, 32'h106, 32'h0, 32'h0000_2083, 32'hDEAD_BEEF, 0, 2, 1);
    run_instr(2'd3, 32'h200, 32'h1234_5678, 32'h0010_2023, $urandom, 1, 0, 1);

    for (int i = 0; i < 40; i++)
      run_instr(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom,
                $urandom_range(0, 2), $urandom_range(0, 2), 1);

    // err together with ack on a load at 0x104.
    w = $urandom;
    wait_stb(n);
    chk("err_fetch_gap", 32'(n), 32'd1);
    core_memwrite = 1'b0; core_memread = 1'b1; core_addr = 32'h104;
    respond(0, w, 1'b1, 1'b0);
    exp_bus.push_back('{1'b0, 32'h104, 32'h0});
    wait_stb(n);
    respond(0, 32'hCAFE_F00D, 1'b1, 1'b1);
    chk("err_fault", 32'(fault), 32'd1);
    chk("err_fault_addr", fault_addr, 32'h104);
    chk("err_cyc", 32'(wb_cyc_o), 32'd0);
    chk("err_rdata", core_rdata, rdata_m);
    bad = 1'b0;
    for (int k = 0; k < 12; k++) begin
      wb_ack_i = k[0];
      @(negedge clk);
      if (core_en || wb_stb_o || !fault) bad = 1'b1;
    end
    wb_ack_i = 1'b0;
    chk("fault_absorbing", 32'(bad), 32'd0);
    chk("fault_instret", instret, 32'(ncommit));
    chk("fault_instr", core_instr, w);
    chk("queues_bus_empty", 32'(exp_bus.size()), 32'd0);
    chk("queues_cmt_empty", 32'(exp_cmt.size()), 32'd0);
    mon_en = 1'b0;

    // Timeout with a silent slave in FETCH.
    reset = 1'b0;
    core_pc = 32'h43;
    @(negedge clk);
    chk("rst2_fault", 32'(fault), 32'd0);
    chk("rst2_instr", core_instr, 32'h0000_0013);
    reset = 1'b1;
    @(negedge clk);
    chk("tmo_adr", wb_adr_o, 32'h40);
    cnt = 0;
    while (wb_stb_o && cnt < 20) begin cnt++; @(negedge clk); end
    chk("tmo_cycles", 32'(cnt), 32'(TMO));
    chk("tmo_fault", 32'(fault), 32'd1);
    chk("tmo_fault_addr", fault_addr, 32'h40);

    // Reset mid-wait drops the strobe without a clock edge; late ack ignored.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_stb_up", 32'(wb_stb_o), 32'd1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_cyc_async", 32'(wb_cyc_o), 32'd0);
    chk("midrst_stb_async", 32'(wb_stb_o), 32'd0);
    @(negedge clk);
    ir = core_instr;
    wb_ack_i = 1'b1; wb_dat_i = 32'hBAD0_BAD0;
    reset = 1'b1;
    @(negedge clk);
    wb_ack_i = 1'b0;
    chk("late_ack_instr", ir, 32'h0000_0013);
    chk("late_ack_instr_hold", core_instr, 32'h0000_0013);
    chk("restart_stb", 32'(wb_stb_o), 32'd1);
    @(negedge clk);
    chk("restart_wait_stb", 32'(wb_stb_o), 32'd1);
    chk("restart_instret", instret, 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
